// File: rtl/fetch_pc_dreg_pkg.sv
// Shared constants and the D-stage register layout for the fetch stage.
// Holds the ISA encodings used by fetch (R-type opcode, J opcode, "no register").
package fetch_pc_dreg_pkg;

    localparam logic [5:0]  IROP         = 6'b000000;
    localparam logic [5:0]  IJ           = 6'b000010;
    localparam logic [4:0]  RNONE        = 5'd0;
    localparam logic [5:0]  NOP_FUNC     = 6'b000000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  func;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] valc;
        logic [31:0] valp;
        logic        valid;
    } d_reg_t;

    // An injected bubble is sll $0,$0,0 with no valid PC attached.
    function automatic d_reg_t nop_dreg(input logic [5:0] nop_func);
        d_reg_t r;
        r.op    = IROP;
        r.func  = nop_func;
        r.rs    = RNONE;
        r.rt    = RNONE;
        r.rd    = RNONE;
        r.valc  = 32'd0;
        r.valp  = 32'd0;
        r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/fetch_pc_dreg_pc_select.sv
// Combinational next-PC mux: redirect > stall > jump predict > sequential.
// Jump prediction is compiled in only when FETCH_JUMP_PREDICT_EN is defined.
module pc_select
    import fetch_pc_dreg_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        stall_i,
    input  logic [5:0]  op_i,
    input  logic [31:0] valc_i,
    output logic [31:0] seq_pc_o,
    output logic [31:0] next_pc_o
);

    logic unused_ok;

    assign seq_pc_o  = pc_i + 32'd4;
    assign unused_ok = ^{target_i[1:0], valc_i, op_i};

    always_comb begin
        next_pc_o = seq_pc_o;
        if (redirect_i) begin
            // Targets are always word aligned; stray low bits are dropped.
            next_pc_o = {target_i[31:2], 2'b00};
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end
`ifdef FETCH_JUMP_PREDICT_EN
        else if (op_i == IJ) begin
            next_pc_o = {seq_pc_o[31:28], valc_i[25:0], 2'b00};
        end
`endif
    end

endmodule

// File: rtl/fetch_pc_dreg.sv
// Fetch-stage PC register plus F->D pipeline register with stall/bubble/redirect.
// Define FETCH_JUMP_PREDICT_EN to redirect fetch on J in the fetch stage itself.
module fetch_pc_dreg
    import fetch_pc_dreg_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [5:0]  NOP_FUNC_P = NOP_FUNC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  f_op,
    input  logic [5:0]  f_func,
    input  logic [4:0]  f_rs,
    input  logic [4:0]  f_rt,
    input  logic [4:0]  f_rd,
    input  logic [31:0] f_valC,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic        e_redirect,
    input  logic [31:0] e_target,
    output logic [31:0] F_valP,
    output logic [5:0]  D_op,
    output logic [5:0]  D_func,
    output logic [4:0]  D_rs,
    output logic [4:0]  D_rt,
    output logic [4:0]  D_rd,
    output logic [31:0] D_valC,
    output logic [31:0] D_valP,
    output logic        D_valid
);

    logic [31:0] pc_q, pc_d, seq_pc;
    d_reg_t      d_q, d_d;

    pc_select u_pc_select (
        .pc_i       (pc_q),
        .redirect_i (e_redirect),
        .target_i   (e_target),
        .stall_i    (F_stall),
        .op_i       (f_op),
        .valc_i     (f_valC),
        .seq_pc_o   (seq_pc),
        .next_pc_o  (pc_d)
    );

    // A squashed or frozen-fetch slot becomes a NOP so no instruction is seen twice.
    always_comb begin
        d_d = d_q;
        if (e_redirect || D_bubble) begin
            d_d = nop_dreg(NOP_FUNC_P);
        end else if (D_stall) begin
            d_d = d_q;
        end else if (F_stall) begin
            d_d = nop_dreg(NOP_FUNC_P);
        end else begin
            d_d.op    = f_op;
            d_d.func  = f_func;
            d_d.rs    = f_rs;
            d_d.rt    = f_rt;
            d_d.rd    = f_rd;
            d_d.valc  = f_valC;
            d_d.valp  = seq_pc;
            d_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
            d_q  <= nop_dreg(NOP_FUNC_P);
        end else begin
            pc_q <= pc_d;
            d_q  <= d_d;
        end
    end

    assign F_valP  = pc_q;
    assign D_op    = d_q.op;
    assign D_func  = d_q.func;
    assign D_rs    = d_q.rs;
    assign D_rt    = d_q.rt;
    assign D_rd    = d_q.rd;
    assign D_valC  = d_q.valc;
    assign D_valP  = d_q.valp;
    assign D_valid = d_q.valid;

endmodule

// File: tb/tb_fetch_pc_dreg.sv
// Self-checking bench for fetch_pc_dreg: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the fetch/decode hand-off.
module tb_fetch_pc_dreg;
    import fetch_pc_dreg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  f_op = '0, f_func = '0;
    logic [4:0]  f_rs = '0, f_rt = '0, f_rd = '0;
    logic [31:0] f_valC = '0;
    logic        F_stall = 1'b0, D_stall = 1'b0, D_bubble = 1'b0, e_redirect = 1'b0;
    logic [31:0] e_target = '0;
    logic [31:0] F_valP;
    logic [5:0]  D_op, D_func;
    logic [4:0]  D_rs, D_rt, D_rd;
    logic [31:0] D_valC, D_valP;
    logic        D_valid;

    fetch_pc_dreg dut (
        .clk(clk), .rst(rst),
        .f_op(f_op), .f_func(f_func), .f_rs(f_rs), .f_rt(f_rt), .f_rd(f_rd), .f_valC(f_valC),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .e_redirect(e_redirect), .e_target(e_target),
        .F_valP(F_valP), .D_op(D_op), .D_func(D_func), .D_rs(D_rs), .D_rt(D_rt), .D_rd(D_rd),
        .D_valC(D_valC), .D_valP(D_valP), .D_valid(D_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

`ifdef FETCH_JUMP_PREDICT_EN
    localparam bit PREDICT = 1'b1;
`else
    localparam bit PREDICT = 1'b0;
`endif

    localparam logic [91:0] NOP_BUNDLE = {6'b000000, 6'b000000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0};

    // Model state: what fetch and decode should hold after each edge.
    logic [31:0] m_pc;
    logic [91:0] m_d;
    logic [91:0] dut_d;

    assign dut_d = {D_op, D_func, D_rs, D_rt, D_rd, D_valC, D_valP, D_valid};

    task automatic model_reset();
        m_pc = 32'h0;
        m_d  = NOP_BUNDLE;
    endtask

    // One clock edge worth of the fetch/decode rules, from the current inputs.
    task automatic model_edge();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (e_redirect || D_bubble)  m_d = NOP_BUNDLE;
        else if (D_stall)            m_d = m_d;
        else if (F_stall)            m_d = NOP_BUNDLE;
        else                         m_d = {f_op, f_func, f_rs, f_rt, f_rd, f_valC, seq, 1'b1};
        if (e_redirect)                        m_pc = e_target & 32'hFFFF_FFFC;
        else if (F_stall)                      m_pc = m_pc;
        else if (PREDICT && f_op == 6'b000010) m_pc = {seq[31:28], f_valC[25:0], 2'b00};
        else                                   m_pc = seq;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Random decoded fields; J is avoided so directed PC constants stay sequential.
    task automatic rand_fetch();
        f_op   = 6'($urandom_range(0, 63));
        if (f_op == 6'b000010) f_op = 6'h23;
        f_func = 6'($urandom_range(0, 63));
        f_rs   = 5'($urandom_range(0, 31));
        f_rt   = 5'($urandom_range(0, 31));
        f_rd   = 5'($urandom_range(0, 31));
        f_valC = $urandom;
    endtask

    task automatic ctrl_idle();
        F_stall = 0; D_stall = 0; D_bubble = 0; e_redirect = 0; e_target = '0;
    endtask

    task automatic do_reset();
        ctrl_idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (F_valP !== 32'h0) begin
            errors++; $display("FAIL reset_pc: got %h want %h", F_valP, 32'h0);
        end
        checks++;
        if (dut_d !== NOP_BUNDLE) begin
            errors++; $display("FAIL reset_d: got %h want %h", dut_d, NOP_BUNDLE);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            rand_fetch();
            tick();
            checks++;
            if (F_valP !== 32'(4 * i) || D_valP !== 32'(4 * i) || D_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_%0d: got pc=%h valp=%h valid=%b want pc=%h valp=%h valid=1",
                         i, F_valP, D_valP, D_valid, 32'(4 * i), 32'(4 * i));
            end
            checks++;
            if (dut_d !== m_d) begin
                errors++; $display("FAIL seq_d_%0d: got %h want %h", i, dut_d, m_d);
            end
        end
    endtask

    task automatic test_stall();
        logic [91:0] snap;
        do_reset();
        rand_fetch(); tick();
        rand_fetch(); tick();
        snap = m_d;
        F_stall = 1; D_stall = 1;
        for (int i = 0; i < 2; i++) begin
            rand_fetch();
            tick();
            checks++;
            if (F_valP !== 32'h8 || dut_d !== snap) begin
                errors++;
                $display("FAIL stall_hold_%0d: got pc=%h d=%h want pc=%h d=%h", i, F_valP, dut_d, 32'h8, snap);
            end
        end
        ctrl_idle();
        rand_fetch();
        tick();
        checks++;
        if (F_valP !== 32'hC || dut_d !== m_d) begin
            errors++;
            $display("FAIL stall_release: got pc=%h d=%h want pc=%h d=%h", F_valP, dut_d, 32'hC, m_d);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        rand_fetch(); tick();
        F_stall = 1; D_stall = 1; e_redirect = 1; e_target = 32'h23;
        rand_fetch();
        tick();
        checks++;
        if (F_valP !== 32'h20 || D_valid !== 1'b0 || D_op !== 6'b000000 || D_rs !== 5'd0) begin
            errors++;
            $display("FAIL redirect: got pc=%h valid=%b op=%h rs=%h want pc=20 valid=0 op=00 rs=00",
                     F_valP, D_valid, D_op, D_rs);
        end
        ctrl_idle();
        rand_fetch();
        tick();
        checks++;
        if (F_valP !== 32'h24 || D_valP !== 32'h24 || D_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_follow: got pc=%h valp=%h valid=%b want pc=24 valp=24 valid=1",
                     F_valP, D_valP, D_valid);
        end
    endtask

    task automatic test_bubble();
        do_reset();
        rand_fetch(); tick();
        D_bubble = 1; D_stall = 1;
        rand_fetch();
        tick();
        checks++;
        if (F_valP !== 32'h8 || dut_d !== NOP_BUNDLE) begin
            errors++;
            $display("FAIL bubble_stall: got pc=%h d=%h want pc=%h d=%h", F_valP, dut_d, 32'h8, NOP_BUNDLE);
        end
        F_stall = 1; D_stall = 0;
        rand_fetch();
        tick();
        checks++;
        if (F_valP !== 32'h8 || dut_d !== NOP_BUNDLE) begin
            errors++;
            $display("FAIL bubble_fstall: got pc=%h d=%h want pc=%h d=%h", F_valP, dut_d, 32'h8, NOP_BUNDLE);
        end
        D_bubble = 0;
        rand_fetch();
        tick();
        checks++;
        if (F_valP !== 32'h8 || D_valid !== 1'b0) begin
            errors++;
            $display("FAIL fstall_nop: got pc=%h valid=%b want pc=8 valid=0", F_valP, D_valid);
        end
        ctrl_idle();
    endtask

    task automatic test_jump();
        logic [31:0] want_pc;
        do_reset();
        rand_fetch();
        f_op = 6'b000010; f_valC = 32'h4;
        want_pc = PREDICT ? 32'h10 : 32'h4;
        tick();
        checks++;
        if (F_valP !== want_pc || D_op !== 6'b000010 || D_valid !== 1'b1 || D_valP !== 32'h4) begin
            errors++;
            $display("FAIL jump: got pc=%h op=%h valid=%b valp=%h want pc=%h op=02 valid=1 valp=4",
                     F_valP, D_op, D_valid, D_valP, want_pc);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rand_fetch(); tick();
        end
        F_stall = 1; D_stall = 1;
        rand_fetch();
        tick();
        checks++;
        if (F_valP !== 32'h14) begin
            errors++; $display("FAIL async_setup: got pc=%h want pc=14", F_valP);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (F_valP !== 32'h0 || D_valid !== 1'b0 || dut_d !== NOP_BUNDLE) begin
            errors++;
            $display("FAIL async_reset: got pc=%h valid=%b d=%h want pc=0 valid=0 d=%h",
                     F_valP, D_valid, dut_d, NOP_BUNDLE);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ctrl_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            f_op   = ($urandom_range(0, 3) == 0) ? 6'b000010 : 6'($urandom_range(0, 63));
            f_func = 6'($urandom_range(0, 63));
            f_rs   = 5'($urandom_range(0, 31));
            f_rt   = 5'($urandom_range(0, 31));
            f_rd   = 5'($urandom_range(0, 31));
            f_valC = $urandom;
            F_stall    = ($urandom_range(0, 3) == 0);
            D_stall    = ($urandom_range(0, 3) == 0);
            D_bubble   = ($urandom_range(0, 7) == 0);
            e_redirect = ($urandom_range(0, 9) == 0);
            e_target   = $urandom;
            tick();
            checks++;
            if (F_valP !== m_pc || dut_d !== m_d) begin
                errors++;
                $display("FAIL random_%0d: got pc=%h d=%h want pc=%h d=%h", i, F_valP, dut_d, m_pc, m_d);
            end
        end
        ctrl_idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_bubble();
        test_jump();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
